// File: rtl/uart_rx_controller.sv
// 8N1 UART receive sequencer paced by a 16x oversampling tick; realigns the tick phase on each start edge.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined (adds parity_err).
module uart_rx_controller #(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk_50MHz,
    input  logic            reset,
    input  logic            rx,
    input  logic            tick,
    output logic            phase_reset,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done,
    output logic            frame_err,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            busy
);

    localparam int CNT_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW      = $clog2(CNT_MAX);
    localparam int NW      = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] HALF_LAST = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] OVS_LAST  = SW'(OVS - 1);
    localparam logic [SW-1:0] SB_LAST   = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] DBIT_LAST = NW'(DBIT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [2:0]      state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic [DBIT-1:0] rx_data_q, rx_data_d;
    logic            rx_done_q, rx_done_d;
    logic            frame_err_q, frame_err_d;
    logic            phase_reset_q, phase_reset_d;
    logic            sync1_q, sync2_q, rx_q;
    logic            rx_s;
    logic            fall;
`ifdef UART_RX_PARITY_EN
    logic            par_bit_q, par_bit_d;
    logic            parity_err_q, parity_err_d;
`endif

    // Two-flop synchroniser, then one extra stage for falling-edge detection.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            rx_q    <= sync2_q;
        end
    end

    assign rx_s = sync2_q;
    assign fall = rx_q & ~rx_s;

    always_comb begin
        state_d       = state_q;
        s_cnt_d       = s_cnt_q;
        n_cnt_d       = n_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        frame_err_d   = frame_err_q;
        rx_done_d     = 1'b0;
        phase_reset_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d     = par_bit_q;
        parity_err_d  = parity_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d       = ST_START;
                    s_cnt_d       = '0;
                    phase_reset_d = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_cnt_q == HALF_LAST) begin
                        s_cnt_d = '0;
                        // A high line at mid-start is a glitch: drop back silently.
                        if (!rx_s) begin
                            n_cnt_d = '0;
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_cnt_q == OVS_LAST) begin
                        s_cnt_d = '0;
                        shift_d = {rx_s, shift_q[DBIT-1:1]};
                        if (n_cnt_q == DBIT_LAST) begin
                            n_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (s_cnt_q == OVS_LAST) begin
                        s_cnt_d   = '0;
                        par_bit_d = rx_s;
                        state_d   = ST_STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (s_cnt_q == SB_LAST) begin
                        s_cnt_d     = '0;
                        rx_data_d   = shift_q;
                        frame_err_d = ~rx_s;
                        rx_done_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_bit_q ^ (^shift_q);
`endif
                        state_d     = ST_IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_cnt_d = '0;
                n_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            s_cnt_q       <= '0;
            n_cnt_q       <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_done_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            phase_reset_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            s_cnt_q       <= s_cnt_d;
            n_cnt_q       <= n_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_done_q     <= rx_done_d;
            frame_err_q   <= frame_err_d;
            phase_reset_q <= phase_reset_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= par_bit_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign phase_reset = phase_reset_q;
    assign rx_data     = rx_data_q;
    assign rx_done     = rx_done_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: divide-by-4 tick generator, directed frames, queue scoreboard.
module tb_uart_rx_controller;

    localparam int BIT_CLKS = 64;

    logic       clk_50MHz = 1'b0;
    logic       reset;
    logic       rx;
    logic       tick;
    logic       phase_reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int pr_seen = 0;
    int exp_pr = 0;

    // {parity_err, frame_err, rx_data}
    logic [9:0] exp_q[$];

    uart_rx_controller dut (
        .clk_50MHz   (clk_50MHz),
        .reset       (reset),
        .rx          (rx),
        .tick        (tick),
        .phase_reset (phase_reset),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .frame_err   (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .busy        (busy)
    );

    // ---------------- clock / reset / tick generator ----------------
    always #10 clk_50MHz = ~clk_50MHz;

    logic [1:0] gen_cnt;
    always @(posedge clk_50MHz) begin
        if (reset || phase_reset) gen_cnt <= 2'd0;
        else                      gen_cnt <= gen_cnt + 2'd1;
    end
    assign tick = (gen_cnt == 2'd3);

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_50MHz) begin
        logic [9:0] e;
        if (phase_reset === 1'b1) pr_seen++;
        if (rx_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rx_done: got strobe with rx_data=%0h, expected no strobe (t=%0t)",
                         rx_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
                check("frame_err", {31'd0, frame_err}, {31'd0, e[8]});
                check("busy_at_done", {31'd0, busy}, 32'd0);
`ifdef UART_RX_PARITY_EN
                check("parity_err", {31'd0, parity_err}, {31'd0, e[9]});
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk_50MHz);
    endtask

    // Start bit with phase_reset/busy timing checks around the falling edge.
    task automatic drive_start(input int n);
        exp_pr++;
        rx = 1'b0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk_50MHz);
            if (j == 2) begin
                check("phase_reset_early", {31'd0, phase_reset}, 32'd0);
                check("busy_before_start", {31'd0, busy}, 32'd0);
            end
            if (j == 3) begin
                check("phase_reset_pulse", {31'd0, phase_reset}, 32'd1);
                check("busy_in_start", {31'd0, busy}, 32'd1);
            end
            if (j == 4) check("phase_reset_single", {31'd0, phase_reset}, 32'd0);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic use_par, input logic par_bit);
        logic perr;
        perr = use_par ? (par_bit ^ (^data)) : 1'b0;
        exp_q.push_back({perr, ~stop_bit, data});
        drive_start(BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(data[i], BIT_CLKS);
        if (use_par) drive_bit(par_bit, BIT_CLKS);
        drive_bit(stop_bit, BIT_CLKS);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] abort_byte;
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_done", {31'd0, rx_done}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_phase_reset", {31'd0, phase_reset}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk_50MHz);
        reset = 1'b0;
        drive_bit(1'b1, 20);

        // Clean frame
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 50);

        // Start glitch: 3 ticks low, then high
        drive_start(12);
        check("glitch_busy_mid", {31'd0, busy}, 32'd1);
        drive_bit(1'b1, 60);
        check("glitch_busy_after", {31'd0, busy}, 32'd0);
        check("glitch_rx_data_held", {24'd0, rx_data}, 32'h0000_00A5);
        check("glitch_frame_err_held", {31'd0, frame_err}, 32'd0);

        // Stop bit low with line held low (break)
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 160);
        check("break_busy", {31'd0, busy}, 32'd0);
        check("break_rx_data_held", {24'd0, rx_data}, 32'h0000_003C);
        drive_bit(1'b1, 200);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 50);

        // Reset during data bit 4 of 0x81
        abort_byte = 8'h81;
        drive_start(BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(abort_byte[i], BIT_CLKS);
        drive_bit(abort_byte[4], 30);
        reset = 1'b1;
        #1;
        check("abort_rx_data", {24'd0, rx_data}, 32'd0);
        check("abort_rx_done", {31'd0, rx_done}, 32'd0);
        check("abort_frame_err", {31'd0, frame_err}, 32'd0);
        check("abort_phase_reset", {31'd0, phase_reset}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        repeat (4) @(negedge clk_50MHz);
        reset = 1'b0;
        drive_bit(1'b1, 50);
        check("after_abort_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 50);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 50);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 50);
`endif

        check("queue_drained", exp_q.size(), 32'd0);
        check("phase_reset_count", pr_seen, exp_pr);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
